// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared constants, address map and FSM state type for spi_reg_peripheral
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  // Bit counter saturates one past a full frame so over-long frames stay distinguishable
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_t;

  // Bit 15 of a frame selects write (1) or read (0)
  function automatic logic frame_is_write(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1];
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rise/fall pulse outputs
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the async input through the chain and keep one extra copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 peripheral with five control registers; SPI_READBACK_EN adds read frames on cipo_o
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       ncs_i,
  output logic       cipo_o,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [6:0] MAX_A      = 7'(MAX_ADDR);
  localparam logic [7:0] SETTLE_END = 8'(SYNC_STAGES + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic copi_sync, copi_rise_unused, copi_fall_unused;
  logic ncs_sync, ncs_rise, ncs_fall_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk_i),
    .sync (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk  (clk),
    .rst  (rst),
    .din  (copi_i),
    .sync (copi_sync),
    .rise (copi_rise_unused),
    .fall (copi_fall_unused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk  (clk),
    .rst  (rst),
    .din  (ncs_i),
    .sync (ncs_sync),
    .rise (ncs_rise),
    .fall (ncs_fall_unused)
  );

  spi_state_t             state;
  logic [4:0]             cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic                   armed;
  logic [7:0]             settle;

  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_ok;

  assign frame_addr = shreg[14:8];
  assign frame_data = shreg[7:0];
  assign frame_ok   = (cnt == CNT_FULL) && frame_is_write(shreg) && (frame_addr <= MAX_A);

  // Wait until the reset value of the nCS synchronizer has been flushed, so that
  // only a genuinely high nCS pin can arm the receiver after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= 8'd0;
    end else if (settle != SETTLE_END) begin
      settle <= settle + 8'd1;
    end
  end

  // Frame receiver FSM and register commit; nCS rise takes priority over SCLK edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 5'd0;
      shreg           <= '0;
      armed           <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      if ((settle == SETTLE_END) && ncs_sync) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          cnt <= 5'd0;
          if (armed && !ncs_sync) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_sync};
            if (cnt != CNT_SAT) begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (frame_ok) begin
            case (frame_addr)
              ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
              ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
              ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
              ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
              ADDR_PWM_DUTY:  pwm_duty_cycle  <= frame_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [6:0] rd_addr;
  logic       rd_is_read;
  logic [7:0] rd_value;
  logic [7:0] shout;
  logic       cipo_q;

  // The 8th rise completes the R/W bit and address; look at them including the incoming bit
  assign rd_addr    = {shreg[5:0], copi_sync};
  assign rd_is_read = ~shreg[6];

  // Readback mux: invalid addresses return zero
  always_comb begin
    rd_value = 8'h00;
    if (rd_addr <= MAX_A) begin
      case (rd_addr)
        ADDR_EN_OUT_LO: rd_value = en_reg_out_7_0;
        ADDR_EN_OUT_HI: rd_value = en_reg_out_15_8;
        ADDR_EN_PWM_LO: rd_value = en_reg_pwm_7_0;
        ADDR_EN_PWM_HI: rd_value = en_reg_pwm_15_8;
        ADDR_PWM_DUTY:  rd_value = pwm_duty_cycle;
        default:        rd_value = 8'h00;
      endcase
    end
  end

  // Shift-out register: load after the address, advance on falls that follow rises 9 onward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shout  <= 8'h00;
      cipo_q <= 1'b0;
    end else if (ncs_sync) begin
      shout  <= 8'h00;
      cipo_q <= 1'b0;
    end else if (state == SHIFT && !ncs_rise) begin
      if (sclk_rise && cnt == 5'd7) begin
        shout  <= rd_is_read ? rd_value : 8'h00;
        cipo_q <= rd_is_read ? rd_value[7] : 1'b0;
      end else if (sclk_fall && cnt >= 5'd9) begin
        shout  <= {shout[6:0], 1'b0};
        cipo_q <= shout[6];
      end
    end
  end

  assign cipo_o = cipo_q;
`else
  logic sclk_fall_unused;
  assign sclk_fall_unused = sclk_fall;
  assign cipo_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - randomized self-checking bench for spi_reg_peripheral
module tb_spi_reg_peripheral;

  logic clk = 1'b0;
  logic rst;
  logic sclk, copi, ncs;
  logic cipo;
  logic [7:0] r0, r1, r2, r3, r4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit checking = 0;

  typedef struct {
    int         due;
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] mregs [5];
  wr_t        pending [$];
  logic [7:0] dregs [5];
  logic [7:0] rb_bits;

  spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk_i          (sclk),
    .copi_i          (copi),
    .ncs_i           (ncs),
    .cipo_o          (cipo),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    dregs[0] = r0;
    dregs[1] = r1;
    dregs[2] = r2;
    dregs[3] = r3;
    dregs[4] = r4;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    pending.delete();
  endtask

  // Compare process: retire model writes whose due edge has passed, then check every output
  always @(negedge clk) begin
    if (checking) begin
      while (pending.size() > 0 && pending[0].due <= cyc) begin
        mregs[pending[0].addr] = pending[0].data;
        void'(pending.pop_front());
      end
      for (int i = 0; i < 5; i++) chk($sformatf("reg%0d", i), dregs[i], mregs[i]);
`ifndef SPI_READBACK_EN
      chk("cipo_tied", cipo, 1'b0);
`endif
    end
  end

  // Send the first n bits of stream (MSB first); optionally pulse reset before bit rst_at
  task automatic send(input logic [31:0] stream, input int n, input int rst_at = -1);
    bit         valid;
    int         addr;
    logic [7:0] rexp;
    valid = 1;
    addr  = int'(stream[30:24]);
    rexp  = (addr <= 4) ? mregs[addr] : 8'h00;
    rb_bits = 8'h00;
    ncs = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        model_reset();
        valid = 0;
        tick(2);
        rst = 1'b0;
        tick(2);
      end
      copi = stream[31-i];
      tick(5);
`ifdef SPI_READBACK_EN
      if (valid && !stream[31] && i >= 8 && i < 16) begin
        rb_bits[15-i] = cipo;
        chk($sformatf("cipo_rise%0d", i + 1), cipo, rexp[15-i]);
      end
`endif
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    tick(5);
    ncs = 1'b1;
    if (valid && n == 16 && stream[31] && stream[30:24] <= 7'd4) begin
      pending.push_back('{due: cyc + 4, addr: int'(stream[30:24]), data: stream[23:16]});
    end
    tick(8);
  endtask

  initial begin
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    model_reset();
    tick(3);
    chk("rst_r0", r0, 8'h00);
    chk("rst_r1", r1, 8'h00);
    chk("rst_r2", r2, 8'h00);
    chk("rst_r3", r3, 8'h00);
    chk("rst_r4", r4, 8'h00);
    chk("rst_cipo", cipo, 1'b0);
    rst = 1'b0;
    checking = 1;
    tick(6);

    send({16'h80F0, 16'h0}, 16);
    chk("lit_out_lo", r0, 8'hF0);
    chk("lit_out_hi_untouched", r1, 8'h00);
    send({16'h8480, 16'h0}, 16);
    chk("lit_duty_80", r4, 8'h80);
    send({16'h84FF, 16'h0}, 16);
    chk("lit_duty_ff", r4, 8'hFF);
    chk("lit_out_lo_kept", r0, 8'hF0);
    send({16'hB0AA, 16'h0}, 16);
    chk("lit_bad_addr", r0, 8'hF0);
    chk("lit_bad_addr_duty", r4, 8'hFF);

    send({16'h81AB, 16'h0}, 12);
    chk("lit_short", r1, 8'h00);
    send({16'h8133, 16'h8000}, 17);
    chk("lit_long", r1, 8'h00);
    send({16'h8177, 16'h0}, 16);
    chk("lit_after_bad_len", r1, 8'h77);

    send({16'h81AA, 16'h0}, 16, 8);
    chk("lit_mid_reset_r1", r1, 8'h00);
    chk("lit_mid_reset_r0", r0, 8'h00);
    send({16'h8155, 16'h0}, 16);
    chk("lit_after_reset", r1, 8'h55);

    send({16'h825A, 16'h0}, 16);
    send({16'h0200, 16'h0}, 16);
    chk("lit_read_keeps", r2, 8'h5A);
`ifdef SPI_READBACK_EN
    chk("lit_readback", rb_bits, 8'h5A);
`endif

    for (int k = 0; k < 40; k++) begin
      int         sel;
      int         n;
      logic       rw;
      logic [6:0] a;
      logic [7:0] d;
      logic [15:0] tail;
      sel  = $urandom_range(0, 9);
      n    = (sel < 6) ? 16 : (sel == 6) ? 12 : (sel == 7) ? 17 : $urandom_range(1, 20);
      rw   = ($urandom_range(0, 3) != 0);
      a    = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(0, 127));
      d    = 8'($urandom);
      tail = 16'($urandom);
      send({rw, a, d, tail}, n);
    end

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
# spi_reg_peripheral

SPI Mode-0 peripheral and control register file feeding the onboarding top level's PWM stage. Receives 16-bit frames on the `ui_in` SPI pins (SCLK, COPI, nCS), synchronizes them into the system clock domain, and commits write data to five 8-bit control registers. The registers drive the output-enable and PWM-enable masks and the duty cycle consumed by the downstream PWM generator.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops per SPI input (≥2).
- `MAX_ADDR`, 4: highest valid register address.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk_i`  in  1  SPI clock, asynchronous to `clk`.
- `copi_i`  in  1  controller-out data, MSB first.
- `ncs_i`  in  1  chip select, active low.
- `cipo_o`  out  1  controller-in data (readback only).
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.

## Operation
- Frame format, MSB first: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
- All three SPI inputs pass through `SYNC_STAGES` flops. Rising and falling SCLK edges and the nCS rising edge are detected by comparing the last synced value against the previous one.
- States:
  - IDLE: wait for synced nCS low; clear the bit counter; go to SHIFT.
  - SHIFT: on each synced SCLK rise, shift COPI into a 16-bit register and increment a 5-bit counter that saturates at 17. On the nCS rise, go to COMMIT.
  - COMMIT: one cycle, then IDLE. The frame is written only when count == 16, bit 15 == 1 and address ≤ `MAX_ADDR`. Any other frame is discarded silently.
- Frames shorter or longer than 16 bits are discarded.
- Unused addresses are ignored. No wrap-around and no aliasing.
- If an SCLK edge and the nCS rise are detected in the same cycle, the nCS rise wins and the SCLK edge is ignored.
- Reset mid-frame: after `rst` releases, an internal `armed` flag stays clear until synced nCS is seen high. A partial frame left over from before the reset is never committed.
- Registers are written only in COMMIT. Writes to one address never disturb the others.
- Input constraint: the SCLK period is at least 8 `clk` cycles.

## Timing
- Reset values: every register output 0x00, `cipo_o` 0, state IDLE, counter 0, `armed` 0.
- Write latency: the new register value is visible at the `clk` edge `SYNC_STAGES`+2 cycles after the `ncs_i` pin rise (4 cycles at the default).
- Back-to-back frames need nCS high for at least `SYNC_STAGES`+2 `clk` cycles.
- Outputs are registered, with no combinational path from the SPI pins.

## Configuration
- `SPI_READBACK_EN` defined: a frame with bit 15 = 0 is a read.
  - After the 8th SCLK rise (address captured), the addressed register, or 0x00 for an invalid address, is loaded into a shift-out register.
  - `cipo_o` presents its MSB from then on and advances one bit on each synced SCLK fall, so the controller samples data bits 7..0 on rises 9–16.
  - `cipo_o` is forced to 0 while nCS is high.
  - Reads never modify registers.
- Macro undefined: read frames are discarded, `cipo_o` is tied to 0, and no shift-out logic is synthesized.

## Structure
- Package `spi_reg_pkg`:
  - `FRAME_BITS`=16.
  - Address constants `ADDR_EN_OUT_LO`..`ADDR_PWM_DUTY`.
  - State enum `spi_state_t` {IDLE, SHIFT, COMMIT}.
- Sub-module `sync_edge_detect`: `SYNC_STAGES`-deep synchronizer with rise/fall pulse outputs and a parameterized reset value. It is instantiated once each for SCLK, COPI and nCS (nCS resets to 1).

## Test plan
- Write 0x00←0xF0 (frame 0x80F0) → `en_reg_out_7_0`=0xF0 by 4 clk after nCS rise; other registers stay 0x00.
- Write 0x04←0x80 (0x8480), then 0x04←0xFF → `pwm_duty_cycle` reads 0x80 then 0xFF; registers 0x00–0x03 unchanged.
- Write to address 0x30 (0xB0AA) → all registers unchanged.
- Only 12 bits clocked, then nCS high → discarded. 17 bits clocked → discarded. A following valid 16-bit frame commits.
- `rst` asserted after 8 bits and released with nCS still low; 8 more bits, nCS rise → no change. Next full frame 0x8155 → `en_reg_out_15_8`=0x55.
- Readback:
  - With `SPI_READBACK_EN`: write 0x02←0x5A, then read frame 0x0200 → `cipo_o` shows 0,1,0,1,1,0,1,0 on SCLK rises 9–16.
  - Without the macro: `cipo_o` stays 0 and registers are unchanged.
